// File: rtl/dpram_pkg.sv
// Shared types and helpers for the byte-enabled dual-port RAM.
package dpram_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_CLEAR = 1'b1
  } dpram_state_t;

  // Upper bound on the data width that byte_merge can handle.
  localparam int unsigned DW_MAX = 1024;
  localparam int unsigned NB_MAX = DW_MAX / 8;

  // Number of byte lanes in a word of the given width.
  function automatic int unsigned bytes_per_word(input int unsigned dw);
    return dw / 8;
  endfunction

  // Replace the bytes of old_w selected by be with the bytes of new_w.
  function automatic logic [DW_MAX-1:0] byte_merge(
    input logic [DW_MAX-1:0] old_w,
    input logic [DW_MAX-1:0] new_w,
    input logic [NB_MAX-1:0] be
  );
    logic [DW_MAX-1:0] r;
    r = old_w;
    for (int unsigned i = 0; i < NB_MAX; i++) begin
      if (be[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/dpram_rd_pipe_m.sv
// Read-data / read-valid pipeline for one RAM port: one or two stages.
module dpram_rd_pipe_m #(
  parameter int DW      = 32,
  parameter int OUT_REG = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rd_en_i,
  input  logic [DW-1:0] rd_word_i,
  output logic [DW-1:0] rdata_o,
  output logic          rvalid_o
);

  logic          v1_q;
  logic [DW-1:0] d1_q;

  // Stage 1: capture the addressed word on an accepted read; data holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      d1_q <= '0;
    end else begin
      v1_q <= rd_en_i;
      if (rd_en_i) d1_q <= rd_word_i;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic          v2_q;
    logic [DW-1:0] d2_q;

    // Stage 2: optional output register, loads only when stage 1 holds fresh data.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v2_q <= 1'b0;
        d2_q <= '0;
      end else begin
        v2_q <= v1_q;
        if (v1_q) d2_q <= d1_q;
      end
    end

    assign rdata_o  = d2_q;
    assign rvalid_o = v2_q;
  end else begin : g_no_out_reg
    assign rdata_o  = d1_q;
    assign rvalid_o = v1_q;
  end

endmodule

// File: rtl/dpram_be_m.sv
// True dual-port RAM with byte enables, collision arbitration and a clear engine.
module dpram_be_m
  import dpram_pkg::*;
#(
  parameter int            AW             = 8,
  parameter int            DW             = 32,
  parameter int            OUT_REG        = 0,
  parameter int            RDW_NEW        = 1,
  parameter int            WR_PRIO_A      = 1,
  parameter int            CLEAR_ON_RESET = 1,
  parameter logic [DW-1:0] INIT_WORD      = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [DW/8-1:0] a_be,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ready,
  output logic [DW-1:0] a_rdata,
  output logic          a_rvalid,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [DW/8-1:0] b_be,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ready,
  output logic [DW-1:0] b_rdata,
  output logic          b_rvalid,
  input  logic          clr_req,
  output logic          clr_busy,
  output logic          coll,
  input  logic          coll_clr
);

  localparam int unsigned NB    = bytes_per_word(DW);
  localparam int unsigned DEPTH = 2 ** AW;

  // Writes commit at the edge, so a read one cycle after a write already sees
  // the new word whichever RDW_NEW setting is chosen; only its range is checked.
  if ((DW % 8) != 0 || RDW_NEW < 0 || RDW_NEW > 1) begin : g_cfg_check
    $error("dpram_be_m: DW must be a multiple of 8 and RDW_NEW must be 0 or 1");
  end

  dpram_state_t state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          coll_q, coll_d;

  logic [DW-1:0] mem_q [DEPTH];

  logic          a_rd_acc, b_rd_acc, a_wr_acc, b_wr_acc, same_wr;
  logic          wa_en, wb_en;
  logic [AW-1:0] wa_addr, wb_addr;
  logic [NB-1:0] wa_be, wb_be;
  logic [DW-1:0] wa_data, wb_data;
  logic [DW-1:0] a_rword, b_rword;

  // Request acceptance: only while ready; zero-byte-enable writes are no-ops.
  always_comb begin
    a_rd_acc = a_req && !a_we && ready_q;
    b_rd_acc = b_req && !b_we && ready_q;
    a_wr_acc = a_req &&  a_we && ready_q && (|a_be);
    b_wr_acc = b_req &&  b_we && ready_q && (|b_be);
    same_wr  = a_wr_acc && b_wr_acc && (a_addr == b_addr);
  end

  // Write commands per memory port. A same-address dual write is folded into
  // the winning port as one merged word so the two ports never race on a byte.
  always_comb begin
    wa_en   = 1'b0;
    wa_addr = a_addr;
    wa_be   = a_be;
    wa_data = a_wdata;
    wb_en   = 1'b0;
    wb_addr = b_addr;
    wb_be   = b_be;
    wb_data = b_wdata;
    if (state_q == ST_CLEAR) begin
      wa_en   = 1'b1;
      wa_addr = cnt_q;
      wa_be   = '1;
      wa_data = INIT_WORD;
    end else begin
      wa_en = a_wr_acc;
      wb_en = b_wr_acc;
      if (same_wr) begin
        if (WR_PRIO_A != 0) begin
          wa_data = DW'(byte_merge(DW_MAX'(b_wdata), DW_MAX'(a_wdata), NB_MAX'(a_be)));
          wa_be   = a_be | b_be;
          wb_en   = 1'b0;
        end else begin
          wb_data = DW'(byte_merge(DW_MAX'(a_wdata), DW_MAX'(b_wdata), NB_MAX'(b_be)));
          wb_be   = a_be | b_be;
          wa_en   = 1'b0;
        end
      end
    end
  end

  // Memory array: byte-lane writes on both ports, never reset.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NB; i++) begin
      if (wa_en && wa_be[i]) mem_q[wa_addr][i*8 +: 8] <= wa_data[i*8 +: 8];
      if (wb_en && wb_be[i]) mem_q[wb_addr][i*8 +: 8] <= wb_data[i*8 +: 8];
    end
  end

  // Addressed words, sampled by the read pipes at the edge (old data on conflicts).
  always_comb begin
    a_rword = mem_q[a_addr];
    b_rword = mem_q[b_addr];
  end

  // Clear FSM next state and fill counter; clr_req while clearing is ignored.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_RUN: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
    ready_d = (state_d == ST_RUN);
    busy_d  = (state_d == ST_CLEAR);
  end

  // Collision flag: a new collision outranks a simultaneous clear.
  always_comb begin
    coll_d = coll_q;
    if (coll_clr) coll_d = 1'b0;
    if (same_wr)  coll_d = 1'b1;
  end

  // Control registers; ready/busy are registered so reset values hold during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= (CLEAR_ON_RESET != 0);
      coll_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      coll_q  <= coll_d;
    end
  end

  dpram_rd_pipe_m #(
    .DW      (DW),
    .OUT_REG (OUT_REG)
  ) u_rd_pipe_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_en_i   (a_rd_acc),
    .rd_word_i (a_rword),
    .rdata_o   (a_rdata),
    .rvalid_o  (a_rvalid)
  );

  dpram_rd_pipe_m #(
    .DW      (DW),
    .OUT_REG (OUT_REG)
  ) u_rd_pipe_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_en_i   (b_rd_acc),
    .rd_word_i (b_rword),
    .rdata_o   (b_rdata),
    .rvalid_o  (b_rvalid)
  );

  assign a_ready  = ready_q;
  assign b_ready  = ready_q;
  assign clr_busy = busy_q;
  assign coll     = coll_q;

endmodule

// File: tb/tb_dpram_be_m.sv
// Directed bench for dpram_be_m: two instances (OUT_REG 0 and 1) share stimulus.
module tb_dpram_be_m;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        a_req, a_we, b_req, b_we, clr_req, coll_clr;
  logic [3:0]  a_be, b_be, a_addr, b_addr;
  logic [31:0] a_wdata, b_wdata;

  logic        u0_a_ready, u0_a_rvalid, u0_b_ready, u0_b_rvalid, u0_clr_busy, u0_coll;
  logic [31:0] u0_a_rdata, u0_b_rdata;
  logic        u1_a_ready, u1_a_rvalid, u1_b_ready, u1_b_rvalid, u1_clr_busy, u1_coll;
  logic [31:0] u1_a_rdata, u1_b_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dpram_be_m #(
    .AW(4), .DW(32), .OUT_REG(0), .RDW_NEW(1), .WR_PRIO_A(1),
    .CLEAR_ON_RESET(1), .INIT_WORD(32'hDEADBEEF)
  ) u0 (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ready(u0_a_ready), .a_rdata(u0_a_rdata), .a_rvalid(u0_a_rvalid),
    .b_req(b_req), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ready(u0_b_ready), .b_rdata(u0_b_rdata), .b_rvalid(u0_b_rvalid),
    .clr_req(clr_req), .clr_busy(u0_clr_busy), .coll(u0_coll), .coll_clr(coll_clr)
  );

  dpram_be_m #(
    .AW(4), .DW(32), .OUT_REG(1), .RDW_NEW(1), .WR_PRIO_A(1),
    .CLEAR_ON_RESET(1), .INIT_WORD(32'hDEADBEEF)
  ) u1 (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ready(u1_a_ready), .a_rdata(u1_a_rdata), .a_rvalid(u1_a_rvalid),
    .b_req(b_req), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ready(u1_b_ready), .b_rdata(u1_b_rdata), .b_rvalid(u1_b_rvalid),
    .clr_req(clr_req), .clr_busy(u1_clr_busy), .coll(u1_coll), .coll_clr(coll_clr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_req = 0; a_we = 0; a_be = '0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_be = '0; b_addr = '0; b_wdata = '0;
    clr_req = 0; coll_clr = 0;
  endtask

  task automatic test_reset();
    int cnt;
    idle();
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({u0_a_ready, u0_b_ready, u1_a_ready} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ready: got %b required 000", {u0_a_ready, u0_b_ready, u1_a_ready});
    end
    n_checks++;
    if ({u0_clr_busy, u0_coll, u0_a_rvalid, u0_b_rvalid} !== 4'b1000) begin
      n_fail++; $display("FAIL reset_flags: got %b required 1000", {u0_clr_busy, u0_coll, u0_a_rvalid, u0_b_rvalid});
    end
    n_checks++;
    if ({u0_a_rdata, u1_b_rdata} !== 64'h0) begin
      n_fail++; $display("FAIL reset_rdata: got %h required 0", {u0_a_rdata, u1_b_rdata});
    end
    repeat (2) tick();
    rst_n = 1'b1;
    cnt = 0;
    while (u0_clr_busy === 1'b1 && cnt < 100) begin
      if (u0_a_ready !== 1'b0) begin
        n_checks++; n_fail++; $display("FAIL ready_during_clear: got %b required 0 at cycle %0d", u0_a_ready, cnt);
      end
      tick();
      cnt++;
    end
    n_checks++;
    if (cnt != 16) begin
      n_fail++; $display("FAIL clear_len_after_reset: got %0d cycles required 16", cnt);
    end
    n_checks++;
    if ({u0_a_ready, u0_b_ready, u1_a_ready} !== 3'b111) begin
      n_fail++; $display("FAIL ready_after_clear: got %b required 111", {u0_a_ready, u0_b_ready, u1_a_ready});
    end
  endtask

  // Back-to-back A reads of every address; u1 lags one cycle.
  task automatic test_read_all(input string tag);
    for (int i = 0; i <= 17; i++) begin
      a_we = 0;
      if (i < 16) begin a_req = 1; a_addr = 4'(i); end
      else a_req = 0;
      tick();
      if (i < 16) begin
        n_checks++;
        if ({u0_a_rvalid, u0_a_rdata} !== {1'b1, 32'hDEADBEEF}) begin
          n_fail++; $display("FAIL %s_u0_addr%0d: got v=%b d=%h required v=1 d=deadbeef", tag, i, u0_a_rvalid, u0_a_rdata);
        end
      end
      if (i >= 1 && i <= 16) begin
        n_checks++;
        if ({u1_a_rvalid, u1_a_rdata} !== {1'b1, 32'hDEADBEEF}) begin
          n_fail++; $display("FAIL %s_u1_addr%0d: got v=%b d=%h required v=1 d=deadbeef", tag, i - 1, u1_a_rvalid, u1_a_rdata);
        end
      end
    end
    n_checks++;
    if ({u0_a_rvalid, u1_a_rvalid} !== 2'b00) begin
      n_fail++; $display("FAIL %s_rvalid_end: got %b required 00", tag, {u0_a_rvalid, u1_a_rvalid});
    end
    idle();
  endtask

  task automatic test_byte_enable();
    idle();
    a_req = 1; a_we = 1; a_be = 4'hF; a_addr = 4'd5; a_wdata = 32'h11223344;
    tick();
    a_be = 4'b0010; a_wdata = 32'h0000AA00;
    tick();
    n_checks++;
    if ({u0_a_rvalid, u1_a_rvalid} !== 2'b00) begin
      n_fail++; $display("FAIL write_no_rvalid: got %b required 00", {u0_a_rvalid, u1_a_rvalid});
    end
    idle();
    b_req = 1; b_addr = 4'd5;
    tick();
    idle();
    n_checks++;
    if ({u0_b_rvalid, u0_b_rdata, u1_b_rvalid} !== {1'b1, 32'h1122AA44, 1'b0}) begin
      n_fail++; $display("FAIL be_lat1: got u0 v=%b d=%h u1 v=%b required 1 1122aa44 0", u0_b_rvalid, u0_b_rdata, u1_b_rvalid);
    end
    tick();
    n_checks++;
    if ({u0_b_rvalid, u0_b_rdata} !== {1'b0, 32'h1122AA44}) begin
      n_fail++; $display("FAIL be_hold: got v=%b d=%h required 0 1122aa44", u0_b_rvalid, u0_b_rdata);
    end
    n_checks++;
    if ({u1_b_rvalid, u1_b_rdata} !== {1'b1, 32'h1122AA44}) begin
      n_fail++; $display("FAIL be_lat2: got v=%b d=%h required 1 1122aa44", u1_b_rvalid, u1_b_rdata);
    end
  endtask

  task automatic test_collision();
    idle();
    a_req = 1; a_we = 1; a_be = 4'hF; a_addr = 4'd3; a_wdata = 32'hAAAAAAAA;
    b_req = 1; b_we = 1; b_be = 4'hF; b_addr = 4'd3; b_wdata = 32'hBBBBBBBB;
    tick();
    idle();
    n_checks++;
    if ({u0_coll, u1_coll} !== 2'b11) begin
      n_fail++; $display("FAIL coll_set: got %b required 11", {u0_coll, u1_coll});
    end
    a_req = 1; a_addr = 4'd3;
    tick();
    idle();
    n_checks++;
    if (u0_a_rdata !== 32'hAAAAAAAA) begin
      n_fail++; $display("FAIL coll_winner: got %h required aaaaaaaa", u0_a_rdata);
    end
    // Byte-wise arbitration: A owns bytes 0-1, B fills bytes 2-3.
    a_req = 1; a_we = 1; a_be = 4'b0011; a_addr = 4'd9; a_wdata = 32'h11111111;
    b_req = 1; b_we = 1; b_be = 4'b1110; b_addr = 4'd9; b_wdata = 32'h22222222;
    tick();
    idle();
    a_req = 1; a_addr = 4'd9;
    tick();
    idle();
    n_checks++;
    if (u0_a_rdata !== 32'h22221111) begin
      n_fail++; $display("FAIL coll_bytewise: got %h required 22221111", u0_a_rdata);
    end
    coll_clr = 1;
    tick();
    idle();
    n_checks++;
    if (u0_coll !== 1'b0) begin
      n_fail++; $display("FAIL coll_clear: got %b required 0", u0_coll);
    end
    a_req = 1; a_we = 1; a_be = 4'hF; a_addr = 4'd4;
    b_req = 1; b_we = 1; b_be = 4'hF; b_addr = 4'd4;
    coll_clr = 1;
    tick();
    idle();
    n_checks++;
    if (u0_coll !== 1'b1) begin
      n_fail++; $display("FAIL coll_set_wins: got %b required 1", u0_coll);
    end
    coll_clr = 1;
    tick();
    idle();
  endtask

  task automatic test_mixed_port();
    idle();
    a_req = 1; a_we = 1; a_be = 4'hF; a_addr = 4'd7; a_wdata = 32'h0;
    tick();
    a_wdata = 32'h5;
    b_req = 1; b_addr = 4'd7;
    tick();
    a_req = 0; a_we = 0;
    n_checks++;
    if ({u0_b_rvalid, u0_b_rdata} !== {1'b1, 32'h0}) begin
      n_fail++; $display("FAIL mixed_old: got v=%b d=%h required 1 00000000", u0_b_rvalid, u0_b_rdata);
    end
    tick();
    idle();
    n_checks++;
    if ({u0_b_rvalid, u0_b_rdata} !== {1'b1, 32'h5}) begin
      n_fail++; $display("FAIL mixed_new: got v=%b d=%h required 1 00000005", u0_b_rvalid, u0_b_rdata);
    end
  endtask

  task automatic test_clear_request();
    int cnt;
    idle();
    a_req = 1; a_we = 1; a_be = 4'hF; a_addr = 4'd2; a_wdata = 32'h12345678;
    tick();
    a_we = 0; clr_req = 1;
    tick();
    idle();
    n_checks++;
    if ({u0_a_rvalid, u0_a_rdata} !== {1'b1, 32'h12345678}) begin
      n_fail++; $display("FAIL clr_read_u0: got v=%b d=%h required 1 12345678", u0_a_rvalid, u0_a_rdata);
    end
    n_checks++;
    if ({u0_a_ready, u0_b_ready, u0_clr_busy} !== 3'b001) begin
      n_fail++; $display("FAIL clr_enter: got %b required 001", {u0_a_ready, u0_b_ready, u0_clr_busy});
    end
    cnt = 0;
    while (u0_a_ready !== 1'b1 && cnt < 100) begin
      // A dropped write to an already-cleared address and an ignored restart.
      a_req = (cnt == 10); a_we = 1; a_be = 4'hF; a_addr = 4'd0; a_wdata = 32'h0;
      clr_req = (cnt == 5);
      tick();
      cnt++;
      if (cnt == 1) begin
        n_checks++;
        if ({u1_a_rvalid, u1_a_rdata} !== {1'b1, 32'h12345678}) begin
          n_fail++; $display("FAIL clr_read_u1: got v=%b d=%h required 1 12345678", u1_a_rvalid, u1_a_rdata);
        end
      end
    end
    idle();
    n_checks++;
    if (cnt != 16) begin
      n_fail++; $display("FAIL clr_req_len: got %0d cycles required 16", cnt);
    end
    n_checks++;
    if ({u0_clr_busy, u1_clr_busy, u1_a_ready} !== 3'b001) begin
      n_fail++; $display("FAIL clr_exit: got %b required 001", {u0_clr_busy, u1_clr_busy, u1_a_ready});
    end
    test_read_all("after_clr_req");
  endtask

  task automatic test_reset_mid_clear();
    int cnt;
    idle();
    a_req = 1; a_we = 1; a_be = 4'hF; a_addr = 4'd1; a_wdata = 32'h0F0F0F0F;
    b_req = 1; b_we = 1; b_be = 4'hF; b_addr = 4'd1; b_wdata = 32'hF0F0F0F0;
    tick();
    idle();
    a_req = 1; a_addr = 4'd1;
    tick();
    idle();
    tick();
    n_checks++;
    if ({u0_coll, u0_a_rdata, u1_a_rdata} !== {1'b1, 32'h0F0F0F0F, 32'h0F0F0F0F}) begin
      n_fail++; $display("FAIL pre_reset_state: got coll=%b d0=%h d1=%h required 1 0f0f0f0f 0f0f0f0f", u0_coll, u0_a_rdata, u1_a_rdata);
    end
    clr_req = 1;
    tick();
    idle();
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({u0_coll, u0_a_ready, u0_a_rvalid, u1_a_rvalid, u0_clr_busy} !== 5'b00001) begin
      n_fail++; $display("FAIL midclr_reset_flags: got %b required 00001", {u0_coll, u0_a_ready, u0_a_rvalid, u1_a_rvalid, u0_clr_busy});
    end
    n_checks++;
    if ({u0_a_rdata, u1_a_rdata} !== 64'h0) begin
      n_fail++; $display("FAIL midclr_reset_rdata: got %h required 0", {u0_a_rdata, u1_a_rdata});
    end
    repeat (3) tick();
    rst_n = 1'b1;
    cnt = 0;
    while (u0_clr_busy === 1'b1 && cnt < 100) begin
      tick();
      cnt++;
    end
    n_checks++;
    if (cnt != 16) begin
      n_fail++; $display("FAIL midclr_restart_len: got %0d cycles required 16", cnt);
    end
    n_checks++;
    if ({u0_a_ready, u1_b_ready} !== 2'b11) begin
      n_fail++; $display("FAIL midclr_ready: got %b required 11", {u0_a_ready, u1_b_ready});
    end
    test_read_all("after_midclr_reset");
  endtask

  initial begin
    test_reset();
    test_read_all("post_reset");
    test_byte_enable();
    test_collision();
    test_mixed_port();
    test_clear_request();
    test_reset_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
